// File: rtl/icache_linefill_responder.sv
// icache_linefill_responder
//
// Memory/L2 stand-in for the icache miss path. Line read requests are queued
// in order. After a fixed latency, one full 512-bit line is returned for each
// request on the rxdat channel. The line data depends only on the line
// address: 32-bit word k holds the byte address of that word. This lets the
// consumer check every line without a reference memory.
//
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where vld && rdy are both high. Once the responder raises rxdat_vld, it
// holds vld and the whole payload stable until that transfer. The icache may
// hold rxdat_rdy high while vld is low; this has no effect.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   downstream_txreq_vld/rdy    request handshake (rdy = request FIFO not full)
//   downstream_txreq_addr       request byte address, bits [5:0] ignored
//   downstream_txreq_entry_idx  requesting MSHR entry
//   downstream_txreq_txnid      upstream transaction id
//   downstream_rxdat_vld/rdy    response handshake
//   downstream_rxdat_data       line data
//   downstream_rxdat_entry_idx  echoed entry index
//   downstream_rxdat_txnid      echoed transaction id
//   downstream_rxdat_opcode     RSP_OPCODE while vld, otherwise 0
//   outstanding_cnt             entries held, including the one being sent
//   fsm_state                   response FSM state (0 idle, 1 wait, 2 send)
module icache_linefill_responder #(
  parameter int REQ_DEPTH       = 4,
  parameter int RSP_LATENCY     = 8,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 512,
  parameter int ENTRY_IDX_WIDTH = 3,
  parameter int TXNID_WIDTH     = 8,
  parameter int OPCODE_WIDTH    = 4,
  parameter logic [OPCODE_WIDTH-1:0] RSP_OPCODE = OPCODE_WIDTH'(4)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          downstream_txreq_vld,
  output logic                          downstream_txreq_rdy,
  input  logic [ADDR_WIDTH-1:0]         downstream_txreq_addr,
  input  logic [ENTRY_IDX_WIDTH-1:0]    downstream_txreq_entry_idx,
  input  logic [TXNID_WIDTH-1:0]        downstream_txreq_txnid,
  output logic                          downstream_rxdat_vld,
  input  logic                          downstream_rxdat_rdy,
  output logic [DATA_WIDTH-1:0]         downstream_rxdat_data,
  output logic [ENTRY_IDX_WIDTH-1:0]    downstream_rxdat_entry_idx,
  output logic [TXNID_WIDTH-1:0]        downstream_rxdat_txnid,
  output logic [OPCODE_WIDTH-1:0]       downstream_rxdat_opcode,
  output logic [$clog2(REQ_DEPTH):0]    outstanding_cnt,
  output logic [1:0]                    fsm_state
);

  localparam int PTR_W   = $clog2(REQ_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int LAT_W   = (RSP_LATENCY > 1) ? $clog2(RSP_LATENCY) : 1;
  localparam int LINE_W  = ADDR_WIDTH - 6;
  localparam int ENTRY_W = LINE_W + ENTRY_IDX_WIDTH + TXNID_WIDTH;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RSP_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [LAT_W-1:0]           cnt_q, cnt_d;
  logic [ENTRY_W-1:0]         mem [REQ_DEPTH];
  logic [PTR_W-1:0]           wr_ptr, rd_ptr;
  logic [CNT_W-1:0]           count_q;
  logic                       push, pop, load;
  logic [LINE_W-1:0]          head_line;
  logic [ENTRY_IDX_WIDTH-1:0] head_entry;
  logic [TXNID_WIDTH-1:0]     head_txnid;

  logic                       vld_q;
  logic [DATA_WIDTH-1:0]      data_q;
  logic [ENTRY_IDX_WIDTH-1:0] entry_q;
  logic [TXNID_WIDTH-1:0]     txnid_q;
  logic [OPCODE_WIDTH-1:0]    op_q;

  // Byte offset within the line plays no part in the response.
  logic unused_offset;
  assign unused_offset = ^downstream_txreq_addr[5:0];

  // Word k of the line = byte address of word k.
  function automatic logic [DATA_WIDTH-1:0] line_data(input logic [LINE_W-1:0] line);
    logic [DATA_WIDTH-1:0] d;
    logic [ADDR_WIDTH-1:0] ba;
    d = '0;
    for (int k = 0; k < 16; k++) begin
      ba = {line, 6'(k * 4)};
      d[32*k +: 32] = 32'(ba);
    end
    return d;
  endfunction

  // No look-ahead at a same-cycle pop: a full FIFO refuses even while draining.
  assign downstream_txreq_rdy = (count_q != CNT_W'(REQ_DEPTH));
  assign push = downstream_txreq_vld && downstream_txreq_rdy;
  assign {head_line, head_entry, head_txnid} = mem[rd_ptr];

  // Response FSM. In IDLE, a request arriving this cycle also counts as
  // pending. This way the latency runs from the accepting edge and not one
  // cycle later.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0 || push) begin
          state_d = ST_WAIT;
          cnt_d   = LAT_LOAD;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_SEND;
          load    = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SEND: begin
        if (vld_q && downstream_rxdat_rdy) begin
          pop = 1'b1;
          if (count_q > CNT_W'(1) || push) begin
            state_d = ST_WAIT;
            cnt_d   = LAT_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FIFO storage holds no reset state; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {downstream_txreq_addr[ADDR_WIDTH-1:6],
                              downstream_txreq_entry_idx, downstream_txreq_txnid};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // The payload is captured once on entry to SEND. It is cleared on the
  // handshake, so idle outputs read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= 1'b0;
      data_q  <= '0;
      entry_q <= '0;
      txnid_q <= '0;
      op_q    <= '0;
    end else if (load) begin
      vld_q   <= 1'b1;
      data_q  <= line_data(head_line);
      entry_q <= head_entry;
      txnid_q <= head_txnid;
      op_q    <= RSP_OPCODE;
    end else if (pop) begin
      vld_q   <= 1'b0;
      data_q  <= '0;
      entry_q <= '0;
      txnid_q <= '0;
      op_q    <= '0;
    end
  end

  assign downstream_rxdat_vld       = vld_q;
  assign downstream_rxdat_data      = data_q;
  assign downstream_rxdat_entry_idx = entry_q;
  assign downstream_rxdat_txnid     = txnid_q;
  assign downstream_rxdat_opcode    = op_q;
  assign outstanding_cnt            = count_q;
  assign fsm_state                  = state_q;

endmodule
